// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/status inputs from the pipeline, stage
// enable/flush controls and performance counters back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_mc_start;
  logic             mc_done;
  logic             mem_busy;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  // Pipeline side: reports hazards, obeys the controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mc_start, mc_done, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           stall_cycles, flush_events
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mc_start, mc_done, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects,
// multi-cycle EX ops and data-memory wait states, plus saturating counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [0:0] {RUN, MC_WAIT} state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic redirect;
  logic load_use;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    pend_d      = pend_q;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
      pend_d      = 1'b0;
    end else if (hz.mem_busy) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      // A result arriving while memory freezes everything must not be lost.
      if (state_q == MC_WAIT && hz.mc_done) pend_d = 1'b1;
    end else if (state_q == MC_WAIT) begin
      if (hz.mc_done || pend_q) begin
        pend_d  = 1'b0;
        state_d = RUN;
      end else begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end
    end else if (hz.ex_mc_start) begin
      // mc_done is not looked at here, so the op always stalls >= 1 cycle.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
      state_d     = MC_WAIT;
    end else if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      redirect   = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    pend_q  <= pend_d;
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redirect && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.idex_en      = idex_en;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_flush  = exmem_flush;
  assign hz.memwb_flush  = memwb_flush;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
endmodule
